// File: rtl/cache_pkg.sv
// Shared cache geometry and refill FSM state encoding, used by the cache arrays,
// cache_control and the miss-handling engine.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int BLOCK_BYTES     = 16;
  localparam int WORDS_PER_BLOCK = BLOCK_BYTES / 2;
  localparam int WORD_OFF_W      = $clog2(WORDS_PER_BLOCK);

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for the refill engine: synchronous clear, enable-gated increment,
// saturates at MAX and flags when it gets there.
module fill_word_counter #(
  parameter int          W   = 4,
  parameter int unsigned MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign term = (cnt_q == W'(MAX));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !term) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss refill engine: issues one pipelined read per word of the missing block,
// writes returned words into the data array in order, then writes the tag.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = WORDS_PER_BLOCK
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [ADDR_W-1:0]        miss_address,
  input  logic                     memory_data_valid,
  input  logic [DATA_W-1:0]        memory_data,
  output logic                     fsm_busy,
  output logic                     memory_req,
  output logic [ADDR_W-1:0]        memory_address,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] data_array_word,
  output logic [DATA_W-1:0]        data_array_data,
  output logic                     write_tag_array,
  output logic [ADDR_W-1:0]        block_base,
  output logic                     fill_done
);

  localparam int WOW = $clog2(WORDS);
  localparam int CW  = WOW + 1;

  fill_state_t       state_q, state_d;
  logic [ADDR_W-1:0] block_base_q, block_base_d;

  logic          cnt_clr;
  logic          issue_en, recv_en;
  logic [CW-1:0] issue_cnt, recv_cnt;
  logic          issue_term, recv_term;
  logic          recv_last;

  // Counters are held cleared while idle so a new refill always starts from word 0.
  assign cnt_clr   = (state_q == IDLE);
  assign issue_en  = (state_q == FILL) && !issue_term;
  assign recv_en   = (state_q == FILL) && memory_data_valid && !recv_term;
  assign recv_last = recv_en && (recv_cnt == CW'(WORDS - 1));

  fill_word_counter #(.W(CW), .MAX(WORDS)) u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (issue_en),
    .cnt  (issue_cnt),
    .term (issue_term)
  );

  fill_word_counter #(.W(CW), .MAX(WORDS)) u_recv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (recv_en),
    .cnt  (recv_cnt),
    .term (recv_term)
  );

  always_comb begin
    state_d      = state_q;
    block_base_d = block_base_q;
    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d      = FILL;
          block_base_d = miss_address & ~ADDR_W'(WORDS * 2 - 1);
        end
      end
      FILL: begin
        if (recv_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      block_base_q <= '0;
    end else begin
      state_q      <= state_d;
      block_base_q <= block_base_d;
    end
  end

  // Request address wraps modulo 2^ADDR_W; the word offset never carries past the block.
  always_comb begin
    fsm_busy         = (state_q == FILL) || miss_detected;
    memory_req       = issue_en;
    memory_address   = '0;
    write_data_array = recv_en;
    data_array_word  = '0;
    data_array_data  = '0;
    write_tag_array  = recv_last;
    fill_done        = recv_last;
    block_base       = block_base_q;
    if (issue_en) begin
      memory_address = block_base_q + (ADDR_W'(issue_cnt) << 1);
    end
    if (recv_en) begin
      data_array_word = recv_cnt[WOW-1:0];
      data_array_data = memory_data;
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a latency-configurable memory model with random return gaps,
// checked against the expected request/write/complete sequence of a block refill.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        memory_req;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  data_array_word;
  logic [15:0] data_array_data;
  logic        write_tag_array;
  logic [15:0] block_base;
  logic        fill_done;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int          due;
    logic [15:0] d;
  } ret_t;

  always #5 clk = ~clk;

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .memory_req        (memory_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_array_word   (data_array_word),
    .data_array_data   (data_array_data),
    .write_tag_array   (write_tag_array),
    .block_base        (block_base),
    .fill_done         (fill_done)
  );

  // One full refill: miss in cycle 0, memory answers each request lat cycles later,
  // optionally withholding a ready word (gap_pct %) to create irregular valids.
  task automatic do_refill(input logic [15:0] addr, input int lat, input int gap_pct,
                           input bit noise_miss, input bit check_idle, output int done_cyc);
    logic [15:0] base;
    ret_t        q[$];
    ret_t        r, nr;
    int          issued, recv;
    bit          fire, done, exp_req, exp_wr, exp_done;
    logic [15:0] exp_addr;
    base     = addr & 16'hFFF0;
    issued   = 0;
    recv     = 0;
    done     = 0;
    done_cyc = -1;
    @(negedge clk);
    miss_detected     = 1'b1;
    miss_address      = addr;
    memory_data_valid = 1'b0;
    memory_data       = 16'($urandom);
    #1;
    n_cmp++;
    if ({fsm_busy, memory_req, write_data_array, write_tag_array} !== 4'b1000) begin
      n_err++;
      $display("FAIL miss_cycle busy/req/wr/tag got %b want 1000",
               {fsm_busy, memory_req, write_data_array, write_tag_array});
    end
    @(posedge clk);
    for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
      @(negedge clk);
      miss_detected = noise_miss ? 1'($urandom_range(1)) : 1'b0;
      miss_address  = 16'h4000;
      fire = (q.size() > 0) && (q[0].due <= cyc) && (int'($urandom_range(99)) >= gap_pct);
      r.d = 16'($urandom);
      if (fire) r = q.pop_front();
      memory_data_valid = fire;
      memory_data       = r.d;
      #1;
      exp_req  = (issued < 8);
      exp_addr = exp_req ? base + 16'(2 * issued) : 16'h0000;
      n_cmp++;
      if ({memory_req, memory_address} !== {exp_req, exp_addr}) begin
        n_err++;
        $display("FAIL request cyc=%0d got req=%b addr=%h want req=%b addr=%h",
                 cyc, memory_req, memory_address, exp_req, exp_addr);
      end
      if (exp_req) begin
        nr.due = cyc + lat;
        nr.d   = 16'($urandom);
        q.push_back(nr);
        issued++;
      end
      exp_wr   = fire && (recv < 8);
      exp_done = exp_wr && (recv == 7);
      n_cmp++;
      if ({write_data_array, data_array_word, data_array_data} !==
          {exp_wr, exp_wr ? 3'(recv) : 3'd0, exp_wr ? r.d : 16'h0000}) begin
        n_err++;
        $display("FAIL data_write cyc=%0d got wr=%b word=%0d data=%h want wr=%b word=%0d data=%h",
                 cyc, write_data_array, data_array_word, data_array_data,
                 exp_wr, exp_wr ? recv : 0, exp_wr ? r.d : 16'h0000);
      end
      n_cmp++;
      if ({write_tag_array, fill_done, fsm_busy, block_base} !== {exp_done, exp_done, 1'b1, base}) begin
        n_err++;
        $display("FAIL tag_busy cyc=%0d got tag=%b done=%b busy=%b base=%h want tag=%b done=%b busy=1 base=%h",
                 cyc, write_tag_array, fill_done, fsm_busy, block_base, exp_done, exp_done, base);
      end
      if (exp_wr) recv++;
      if (exp_done) begin
        done     = 1;
        done_cyc = cyc;
      end
      @(posedge clk);
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL refill_timeout addr=%h got %0d words want 8", addr, recv);
    end
    $display("refill miss=%h base=%h lat=%0d gap=%0d done_cycle=%0d", addr, base, lat, gap_pct, done_cyc);
    if (check_idle) begin
      @(negedge clk);
      miss_detected     = 1'b0;
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
      #1;
      n_cmp++;
      if ({fsm_busy, memory_req, write_data_array, write_tag_array, fill_done} !== 5'b0) begin
        n_err++;
        $display("FAIL after_fill busy/req/wr/tag/done got %b want 00000",
                 {fsm_busy, memory_req, write_data_array, write_tag_array, fill_done});
      end
      @(posedge clk);
      memory_data_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++;
    if ({fsm_busy, memory_req, memory_address, write_data_array, data_array_word, data_array_data,
         write_tag_array, block_base, fill_done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b req=%b addr=%h wr=%b tag=%b base=%h done=%b want all 0",
               fsm_busy, memory_req, memory_address, write_data_array, write_tag_array, block_base, fill_done);
    end
    miss_detected = 1'b1;
    #1;
    n_cmp++;
    if ({fsm_busy, memory_req} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_busy_follows_miss got busy=%b req=%b want busy=1 req=0", fsm_busy, memory_req);
    end
    miss_detected = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_single();
    int dc;
    do_refill(16'h1234, 4, 0, 1'b0, 1'b1, dc);
    n_cmp++;
    if (dc !== 12) begin
      n_err++;
      $display("FAIL single_done_cycle got %0d want 12", dc);
    end
  endtask

  task automatic test_irregular();
    int dc;
    do_refill(16'($urandom), 2, 60, 1'b0, 1'b1, dc);
    n_cmp++;
    if (dc < 10) begin
      n_err++;
      $display("FAIL irregular_done_cycle got %0d want >=10", dc);
    end
  endtask

  task automatic test_spurious();
    int dc;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      miss_detected     = 1'b0;
      memory_data_valid = 1'b1;
      memory_data       = 16'($urandom);
      #1;
      n_cmp++;
      if ({fsm_busy, memory_req, write_data_array, write_tag_array} !== 4'b0) begin
        n_err++;
        $display("FAIL idle_valid i=%0d busy/req/wr/tag got %b want 0000",
                 i, {fsm_busy, memory_req, write_data_array, write_tag_array});
      end
      @(posedge clk);
    end
    memory_data_valid = 1'b0;
    do_refill(16'h2468, 3, 30, 1'b1, 1'b1, dc);
  endtask

  task automatic test_reset_mid();
    int dc;
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = 16'h5678;
    @(posedge clk);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      miss_detected     = 1'b0;
      memory_data_valid = 1'b0;
      #1;
      n_cmp++;
      if ({memory_req, memory_address} !== {1'b1, 16'h5670 + 16'(2 * (cyc - 1))}) begin
        n_err++;
        $display("FAIL reset_mid_req cyc=%0d got req=%b addr=%h want req=1 addr=%h",
                 cyc, memory_req, memory_address, 16'h5670 + 16'(2 * (cyc - 1)));
      end
      @(posedge clk);
    end
    @(negedge clk);
    memory_data_valid = 1'b1;
    rst               = 1'b1;
    #1;
    n_cmp++;
    if ({fsm_busy, memory_req, memory_address, write_data_array, data_array_word, data_array_data,
         write_tag_array, block_base, fill_done} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs got busy=%b req=%b addr=%h wr=%b tag=%b base=%h done=%b want all 0",
               fsm_busy, memory_req, memory_address, write_data_array, write_tag_array, block_base, fill_done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      memory_data_valid = 1'($urandom_range(1));
      memory_data       = 16'($urandom);
      #1;
      n_cmp++;
      if ({fsm_busy, memory_req, write_data_array, write_tag_array, fill_done} !== 5'b0) begin
        n_err++;
        $display("FAIL late_return i=%0d busy/req/wr/tag/done got %b want 00000",
                 i, {fsm_busy, memory_req, write_data_array, write_tag_array, fill_done});
      end
    end
    memory_data_valid = 1'b0;
    $display("reset mid-fill at cycle 6, refill abandoned");
    do_refill(16'h5678, 4, 0, 1'b0, 1'b1, dc);
  endtask

  task automatic test_wrap();
    int dc;
    do_refill(16'hFFFA, 3, 0, 1'b0, 1'b1, dc);
    n_cmp++;
    if (dc !== 11) begin
      n_err++;
      $display("FAIL wrap_done_cycle got %0d want 11", dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2;
    do_refill(16'h0010, 2, 0, 1'b0, 1'b0, dc1);
    do_refill(16'h0020, 2, 0, 1'b0, 1'b1, dc2);
    n_cmp++;
    if ({dc1, dc2} !== {32'd10, 32'd10}) begin
      n_err++;
      $display("FAIL back_to_back_done got %0d,%0d want 10,10", dc1, dc2);
    end
  endtask

  task automatic test_random();
    int dc;
    for (int i = 0; i < 6; i++) begin
      do_refill(16'($urandom), $urandom_range(6, 1), $urandom_range(50), 1'($urandom_range(1)),
                1'($urandom_range(1)), dc);
    end
  endtask

  initial begin
    rst               = 1'b1;
    miss_detected     = 1'b0;
    miss_address      = 16'h0000;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0000;
    test_reset();
    test_single();
    test_irregular();
    test_spurious();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
